icache_direct_mapped: RTL

- Direct-mapped, read-only instruction cache between the IF stage and the instruction-memory block port.
- Replaces the current pass-through wiring of Instr_address_2IC / Instr1_fIC / Instr2_fIC.
- On a hit, returns the fetched word (and the next word) in the same cycle.
- On a miss, stalls IF, fetches one 256-bit line from IM using the iBlkRead handshake, installs it, then serves the hit.

---
 rtl/icache_direct_mapped_if.sv | 32 +++
 rtl/icache_direct_mapped.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and instruction-memory-side signal bundle of the direct-mapped
// instruction cache. The cache sits on the slave modport. The master modport
// is the surrounding environment: the IF stage plus the instruction-memory
// block port.
interface icache_direct_mapped_if;
    // IF stage side
    logic [31:0]  Instr_address_2IC;
    logic [31:0]  Instr1_fIC;
    logic [31:0]  Instr2_fIC;
    logic         Instr2_valid_fIC;
    logic         IC_stall;
    logic         Invalidate_IC;
    // instruction-memory block port side
    logic [31:0]  Instr_address_2IM;
    logic         iBlkRead;
    logic [255:0] block_read_fIM;
    logic         block_read_fIM_valid;
    // statistics
    logic [31:0]  Miss_count;

    modport master (
        output Instr_address_2IC, Invalidate_IC, block_read_fIM, block_read_fIM_valid,
        input  Instr1_fIC, Instr2_fIC, Instr2_valid_fIC, IC_stall,
        input  Instr_address_2IM, iBlkRead, Miss_count
    );

    modport slave (
        input  Instr_address_2IC, Invalidate_IC, block_read_fIM, block_read_fIM_valid,
        output Instr1_fIC, Instr2_fIC, Instr2_valid_fIC, IC_stall,
        output Instr_address_2IM, iBlkRead, Miss_count
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache with 32-byte (8-word) lines.
// A hit returns the addressed word and its successor in the same cycle. A
// miss stalls IF, fetches one 256-bit line over the iBlkRead handshake,
// installs it and then serves the access as a hit. The successor word is
// never taken from the following line.
module icache_direct_mapped #(
    parameter  int NUM_LINES  = 32,
    localparam int INDEX_BITS = $clog2(NUM_LINES)
) (
    input logic CLK,
    input logic RESET,
    icache_direct_mapped_if.slave bus
);

    localparam int TAG_BITS = 27 - INDEX_BITS;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Extract 32-bit word 'off' (0..7) from a 256-bit line.
    function automatic logic [31:0] word_sel(input logic [255:0] line, input logic [2:0] off);
        word_sel = line[{off, 5'b00000} +: 32];
    endfunction

    state_t                 state_r;
    state_t                 next_state_s;
    logic [26:0]            fill_addr_r;
    logic [31:0]            miss_count_r;
    logic [NUM_LINES-1:0]   valid_r;
    logic [TAG_BITS-1:0]    tag_r  [NUM_LINES];
    logic [255:0]           data_r [NUM_LINES];

    logic [2:0]             offset_s;
    logic [INDEX_BITS-1:0]  index_s;
    logic [TAG_BITS-1:0]    tag_s;
    logic [255:0]           line_s;
    logic                   hit_s;
    logic                   fill_done_s;
    logic [INDEX_BITS-1:0]  fill_index_s;
    logic [TAG_BITS-1:0]    fill_tag_s;

    logic                   stall_s;
    logic [31:0]            instr1_s;
    logic [31:0]            instr2_s;
    logic                   instr2_valid_s;
    logic                   blk_read_s;
    logic [31:0]            im_addr_s;

    // Address split of the fetch PC and of the line currently being filled.
    assign offset_s     = bus.Instr_address_2IC[4:2];
    assign index_s      = bus.Instr_address_2IC[4+INDEX_BITS:5];
    assign tag_s        = bus.Instr_address_2IC[31:5+INDEX_BITS];
    assign fill_index_s = fill_addr_r[INDEX_BITS-1:0];
    assign fill_tag_s   = fill_addr_r[26:INDEX_BITS];

    // Combinational lookup; an invalid line never hits whatever its tag holds.
    assign line_s      = data_r[index_s];
    assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign fill_done_s = (state_r == ST_FILL) && bus.block_read_fIM_valid;

    // Next-state decode and fetch/fill outputs; defaults describe a stalled cache.
    always_comb begin
        next_state_s   = state_r;
        stall_s        = 1'b1;
        instr1_s       = 32'h0;
        instr2_s       = 32'h0;
        instr2_valid_s = 1'b0;
        blk_read_s     = 1'b0;
        im_addr_s      = 32'h0;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    stall_s  = 1'b0;
                    instr1_s = word_sel(line_s, offset_s);
                    if (offset_s != 3'd7) begin
                        instr2_s       = word_sel(line_s, offset_s + 3'd1);
                        instr2_valid_s = 1'b1;
                    end else begin
                        // Last word of the line: no cross-line read.
                        instr2_s       = 32'h0;
                        instr2_valid_s = 1'b0;
                    end
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_FILL: begin
                // The fill is tied to fill_addr_r; PC changes here do not disturb it.
                blk_read_s = 1'b1;
                im_addr_s  = {fill_addr_r, 5'b00000};
                if (bus.block_read_fIM_valid) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.IC_stall          = stall_s;
    assign bus.Instr1_fIC        = instr1_s;
    assign bus.Instr2_fIC        = instr2_s;
    assign bus.Instr2_valid_fIC  = instr2_valid_s;
    assign bus.iBlkRead          = blk_read_s;
    assign bus.Instr_address_2IM = im_addr_s;
    assign bus.Miss_count        = miss_count_r;

    // FSM state, captured miss line address and wrapping miss counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            fill_addr_r  <= 27'h0;
            miss_count_r <= 32'h0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_IDLE) && !hit_s) begin
                fill_addr_r  <= bus.Instr_address_2IC[31:5];
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    // Valid bits: invalidate clears first so a coincident fill still lands valid.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else begin
            if (bus.Invalidate_IC) begin
                valid_r <= {NUM_LINES{1'b0}};
            end
            if (fill_done_s) begin
                valid_r[fill_index_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge CLK) begin
        if (fill_done_s) begin
            tag_r[fill_index_s]  <= fill_tag_s;
            data_r[fill_index_s] <= bus.block_read_fIM;
        end
    end

endmodule
